jtframe_rom_arb: RTL and testbench

- Parametrised successor to the fixed 9-slot SDRAM ROM slot block; serves SLOTS read-only ROM clients from one SDRAM read port.
- Each slot has a one-word cache, a per-slot SDRAM offset and a per-slot 8/16-bit data width.
- Arbitration between slots is either fixed priority or round-robin, selected by parameter.
- Sits between the game cores (CPU, GFX, PCM fetchers) and the jtframe SDRAM controller.

---
 rtl/jtframe_rom_arb.sv | 109 ++++++++++
 tb/tb_jtframe_rom_arb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_rom_arb.sv
// jtframe_rom_arb: shares one SDRAM read port among SLOTS ROM clients.
// Each slot keeps a one-word cache; only one miss is fetched at a time.
module jtframe_rom_arb #(
    parameter int                  SLOTS   = 4,
    parameter int                  AW      = 22,
    parameter logic [SLOTS-1:0]    DW8     = '0,
    parameter logic [SLOTS*22-1:0] OFFSETS = '0,
    parameter bit                  RR      = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [SLOTS-1:0]      slot_cs,
    input  logic [SLOTS*AW-1:0]   slot_addr,
    output logic [SLOTS-1:0]      slot_ok,
    output logic [SLOTS*16-1:0]   slot_dout,
    input  logic                  downloading,
    output logic                  sdram_req,
    input  logic                  sdram_ack,
    input  logic                  data_rdy,
    input  logic [15:0]           data_read,
    output logic [21:0]           sdram_addr
);
    localparam int PW = SLOTS > 1 ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

    state_t              r_state, w_next;
    logic [21:0]         w_waddr [SLOTS];
    logic [21:0]         r_tag   [SLOTS];
    logic [15:0]         r_data  [SLOTS];
    logic [SLOTS-1:0]    w_hit, w_pend, r_valid;
    logic [SLOTS*16-1:0] w_dout;
    logic [21:0]         r_wlatch;
    logic [PW-1:0]       r_gnt, r_ptr, w_gnt;
    logic                w_gnt_ok, w_fill, w_issue;
    int                  w_j;

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            w_waddr[i] = DW8[i] ? 22'(slot_addr[AW*i+1 +: AW-1]) : 22'(slot_addr[AW*i +: AW]);
            w_hit[i] = slot_cs[i] & r_valid[i] & (r_tag[i] == w_waddr[i]);
            w_dout[16*i +: 16] = DW8[i] ? {8'd0, slot_addr[AW*i] ? r_data[i][15:8] : r_data[i][7:0]} : r_data[i];
        end
        w_pend = slot_cs & ~w_hit;
    end

    // Scan from the last candidate back to the first so the earliest pending slot wins
    always_comb begin
        w_gnt_ok = 1'b0;
        w_gnt    = '0;
        w_j      = 0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            w_j = RR ? (int'(r_ptr) + k) % SLOTS : k;
            if (w_pend[w_j]) begin
                w_gnt_ok = 1'b1;
                w_gnt    = PW'(w_j);
            end
        end
    end

    assign w_issue   = ~downloading & (r_state == IDLE) & w_gnt_ok;
    assign w_fill    = ~downloading & data_rdy & (((r_state == WAIT_ACK) & sdram_ack) | (r_state == WAIT_DATA));
    assign sdram_req = (r_state == WAIT_ACK);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = w_issue ? WAIT_ACK : IDLE;
            WAIT_ACK:  w_next = sdram_ack ? (data_rdy ? IDLE : WAIT_DATA) : WAIT_ACK;
            WAIT_DATA: w_next = data_rdy ? IDLE : WAIT_DATA;
            default:   w_next = IDLE;
        endcase
        if (downloading) w_next = IDLE;
    end

    always_ff @(posedge clk) r_state <= !rstn ? IDLE : w_next;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            slot_ok    <= '0;
            slot_dout  <= '0;
            sdram_addr <= '0;
            r_valid    <= '0;
            r_wlatch   <= '0;
            r_gnt      <= '0;
            r_ptr      <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            slot_ok   <= downloading ? '0 : w_hit;
            slot_dout <= w_dout;
            if (downloading) begin
                r_valid <= '0;
            end else if (w_fill) begin
                r_valid[r_gnt] <= 1'b1;
                r_tag[r_gnt]   <= r_wlatch;
                r_data[r_gnt]  <= data_read;
            end
            if (w_issue) begin
                r_gnt      <= w_gnt;
                r_wlatch   <= w_waddr[w_gnt];
                sdram_addr <= OFFSETS[22*w_gnt +: 22] + w_waddr[w_gnt];
                r_ptr      <= (int'(w_gnt) == SLOTS - 1) ? '0 : w_gnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_jtframe_rom_arb.sv
// tb_jtframe_rom_arb: fixed-priority and round-robin instances driven in parallel,
// checked against a transaction-level model of the slot caches and the SDRAM port.
module tb_jtframe_rom_arb;
    localparam int S  = 4;
    localparam int AW = 22;
    localparam logic [S-1:0]    DW8  = 4'b0100;
    localparam logic [S*22-1:0] OFFS = {22'h3FFFF0, 22'h0, 22'h50000, 22'h0};

    logic          clk = 1'b0, rstn = 1'b0, dl = 1'b0;
    logic [S-1:0]  cs = '0;
    logic [S*AW-1:0] addr = '0;
    logic [1:0]    ack = '0, rdy = '0, req;
    logic [15:0]   rd   [2];
    logic [S-1:0]  ok   [2];
    logic [S*16-1:0] dout [2];
    logic [21:0]   sa   [2];

    int n_cmp = 0, n_bad = 0;
    bit auto_resp = 1'b0;

    // model state: per-instance cache, transaction phase (0 free, 1 awaiting ack, 2 awaiting data)
    bit mv [2][S];
    int mt [2][S];
    int md [2][S];
    int ph [2], mg [2], mw [2], mp [2], eaddr [2];
    logic [S-1:0] eok [2];
    int edout [2][S];

    always #5 clk = ~clk;

    jtframe_rom_arb #(.SLOTS(S), .AW(AW), .DW8(DW8), .OFFSETS(OFFS), .RR(1'b0)) u0 (
        .clk(clk), .rstn(rstn), .slot_cs(cs), .slot_addr(addr), .slot_ok(ok[0]), .slot_dout(dout[0]),
        .downloading(dl), .sdram_req(req[0]), .sdram_ack(ack[0]), .data_rdy(rdy[0]),
        .data_read(rd[0]), .sdram_addr(sa[0]));

    jtframe_rom_arb #(.SLOTS(S), .AW(AW), .DW8(DW8), .OFFSETS(OFFS), .RR(1'b1)) u1 (
        .clk(clk), .rstn(rstn), .slot_cs(cs), .slot_addr(addr), .slot_ok(ok[1]), .slot_dout(dout[1]),
        .downloading(dl), .sdram_req(req[1]), .sdram_ack(ack[1]), .data_rdy(rdy[1]),
        .data_read(rd[1]), .sdram_addr(sa[1]));

    function automatic int waddr_of(input int s);
        int a;
        a = int'(addr[AW*s +: AW]);
        return DW8[s] ? a >> 1 : a;
    endfunction

    task automatic model_step(input int m);
        bit h [S];
        int pick, s;
        for (int i = 0; i < S; i++) begin
            h[i] = cs[i] && mv[m][i] && (mt[m][i] == waddr_of(i));
            eok[m][i] = rstn && !dl && h[i];
            edout[m][i] = !rstn ? 0 : !DW8[i] ? md[m][i] : addr[AW*i] ? (md[m][i] >> 8) & 255 : md[m][i] & 255;
        end
        if (!rstn) begin
            for (int i = 0; i < S; i++) mv[m][i] = 1'b0;
            ph[m] = 0; mp[m] = 0; eaddr[m] = 0;
        end else if (dl) begin
            for (int i = 0; i < S; i++) mv[m][i] = 1'b0;
            ph[m] = 0;
        end else if (ph[m] == 0) begin
            pick = -1;
            for (int k = 0; k < S; k++) begin
                s = (m == 1) ? (mp[m] + k) % S : k;
                if (pick < 0 && cs[s] && !h[s]) pick = s;
            end
            if (pick >= 0) begin
                ph[m] = 1; mg[m] = pick; mw[m] = waddr_of(pick);
                eaddr[m] = (int'(OFFS[22*pick +: 22]) + mw[m]) % (1 << 22);
                mp[m] = (pick + 1) % S;
            end
        end else if ((ph[m] == 1 && ack[m] && rdy[m]) || (ph[m] == 2 && rdy[m])) begin
            mv[m][mg[m]] = 1'b1; mt[m][mg[m]] = mw[m]; md[m][mg[m]] = int'(rd[m]); ph[m] = 0;
        end else if (ph[m] == 1 && ack[m]) begin
            ph[m] = 2;
        end
    endtask

    task automatic respond();
        for (int m = 0; m < 2; m++) begin
            rd[m]  = 16'($urandom);
            ack[m] = req[m] && $urandom_range(0, 2) == 0;
            rdy[m] = req[m] ? (ack[m] && $urandom_range(0, 3) == 0) :
                     (ph[m] == 2) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
        end
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        if (auto_resp) respond();
    endtask

    task automatic flush();
        cs = '0; ack = '0; rdy = '0; dl = 1'b1;
        tick();
        dl = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick(); tick();
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (ok[m] !== '0) begin n_bad++; $display("FAIL reset_ok[%0d]: got %b want 0", m, ok[m]); end
            n_cmp++; if (dout[m] !== '0) begin n_bad++; $display("FAIL reset_dout[%0d]: got %h want 0", m, dout[m]); end
            n_cmp++; if (req[m] !== 1'b0) begin n_bad++; $display("FAIL reset_req[%0d]: got %b want 0", m, req[m]); end
            n_cmp++; if (sa[m] !== 22'h0) begin n_bad++; $display("FAIL reset_addr[%0d]: got %h want 0", m, sa[m]); end
        end
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (ok[0] !== '0 || req[0] !== 1'b0 || sa[0] !== 22'h0) begin
                n_bad++; $display("FAIL idle: ok=%b req=%b addr=%h want 0/0/0", ok[0], req[0], sa[0]);
            end
        end
    endtask

    task automatic test_miss_fill_hit();
        cs = 4'b0010; addr[AW*1 +: AW] = 22'h123;
        tick();
        n_cmp++; if (req[0] !== 1'b1) begin n_bad++; $display("FAIL miss_req: got %b want 1", req[0]); end
        n_cmp++; if (sa[0] !== 22'h50123) begin n_bad++; $display("FAIL miss_addr: got %h want 50123", sa[0]); end
        tick();
        n_cmp++; if (req[0] !== 1'b1 || sa[0] !== 22'h50123) begin n_bad++; $display("FAIL req_hold: req=%b addr=%h want 1/50123", req[0], sa[0]); end
        ack = 2'b11;
        tick();
        ack = 2'b00;
        n_cmp++; if (req[0] !== 1'b0) begin n_bad++; $display("FAIL req_after_ack: got %b want 0", req[0]); end
        tick();
        rdy = 2'b11; rd[0] = 16'hBEEF; rd[1] = 16'hBEEF;
        tick();
        rdy = 2'b00;
        n_cmp++; if (ok[0][1] !== 1'b0) begin n_bad++; $display("FAIL ok_at_fill: got %b want 0", ok[0][1]); end
        tick();
        n_cmp++; if (ok[0][1] !== 1'b1) begin n_bad++; $display("FAIL hit_ok: got %b want 1", ok[0][1]); end
        n_cmp++; if (dout[0][31:16] !== 16'hBEEF) begin n_bad++; $display("FAIL hit_dout: got %h want beef", dout[0][31:16]); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (req[0] !== 1'b0 || ok[0][1] !== 1'b1) begin n_bad++; $display("FAIL hit_hold: req=%b ok=%b want 0/1", req[0], ok[0][1]); end
        end
    endtask

    task automatic test_8bit();
        cs = 4'b0100; addr[AW*2 +: AW] = 22'h201;
        tick();
        n_cmp++; if (req[0] !== 1'b1 || sa[0] !== 22'h100) begin n_bad++; $display("FAIL b8_req: req=%b addr=%h want 1/100", req[0], sa[0]); end
        ack = 2'b11; rdy = 2'b11; rd[0] = 16'h34AB; rd[1] = 16'h34AB;
        tick();
        ack = 2'b00; rdy = 2'b00;
        n_cmp++; if (req[0] !== 1'b0) begin n_bad++; $display("FAIL b8_same_cycle: req=%b want 0", req[0]); end
        tick();
        n_cmp++; if (ok[0][2] !== 1'b1 || dout[0][47:32] !== 16'h0034) begin n_bad++; $display("FAIL b8_hi: ok=%b dout=%h want 1/0034", ok[0][2], dout[0][47:32]); end
        addr[AW*2 +: AW] = 22'h200;
        tick();
        n_cmp++; if (ok[0][2] !== 1'b1 || dout[0][47:32] !== 16'h00AB || req[0] !== 1'b0) begin
            n_bad++; $display("FAIL b8_lo: ok=%b dout=%h req=%b want 1/00ab/0", ok[0][2], dout[0][47:32], req[0]);
        end
    endtask

    task automatic test_arbitration();
        logic [21:0] e0 [3];
        logic [21:0] e1 [3];
        int t;
        e0 = '{22'h40, 22'hF8, 22'h10};
        e1 = '{22'h10, 22'h40, 22'hF8};
        flush();
        cs = 4'b1101;
        addr[AW*0 +: AW] = 22'h40; addr[AW*2 +: AW] = 22'h1F0; addr[AW*3 +: AW] = 22'h20;
        for (int g = 0; g < 3; g++) begin
            t = 0;
            while (req !== 2'b11 && t < 6) begin tick(); t++; end
            n_cmp++; if (req !== 2'b11) begin n_bad++; $display("FAIL arb_req%0d: got %b want 11", g, req); end
            n_cmp++; if (sa[0] !== e0[g]) begin n_bad++; $display("FAIL arb_fixed%0d: got %h want %h", g, sa[0], e0[g]); end
            n_cmp++; if (sa[1] !== e1[g]) begin n_bad++; $display("FAIL arb_rr%0d: got %h want %h", g, sa[1], e1[g]); end
            ack = 2'b11; rdy = 2'b11; rd[0] = 16'(g); rd[1] = 16'(g);
            tick();
            ack = 2'b00; rdy = 2'b00;
        end
        tick();
        n_cmp++; if (ok[0] !== 4'b1101 || ok[1] !== 4'b1101) begin n_bad++; $display("FAIL arb_ok: got %b/%b want 1101", ok[0], ok[1]); end
    endtask

    task automatic test_addr_change();
        flush();
        cs = 4'b0001; addr[AW*0 +: AW] = 22'h10;
        tick();
        n_cmp++; if (req[0] !== 1'b1 || sa[0] !== 22'h10) begin n_bad++; $display("FAIL chg_req1: req=%b addr=%h want 1/10", req[0], sa[0]); end
        ack = 2'b11;
        tick();
        ack = 2'b00; addr[AW*0 +: AW] = 22'h20;
        tick();
        rdy = 2'b11; rd[0] = 16'h1111; rd[1] = 16'h1111;
        tick();
        rdy = 2'b00;
        tick();
        n_cmp++; if (ok[0][0] !== 1'b0) begin n_bad++; $display("FAIL chg_stale_ok: got %b want 0", ok[0][0]); end
        n_cmp++; if (req[0] !== 1'b1 || sa[0] !== 22'h20) begin n_bad++; $display("FAIL chg_req2: req=%b addr=%h want 1/20", req[0], sa[0]); end
        ack = 2'b11; rdy = 2'b11; rd[0] = 16'h2222; rd[1] = 16'h2222;
        tick();
        ack = 2'b00; rdy = 2'b00;
        tick();
        n_cmp++; if (ok[0][0] !== 1'b1 || dout[0][15:0] !== 16'h2222) begin n_bad++; $display("FAIL chg_hit: ok=%b dout=%h want 1/2222", ok[0][0], dout[0][15:0]); end
    endtask

    task automatic test_download();
        dl = 1'b1; rdy = 2'b11; rd[0] = 16'hDEAD; rd[1] = 16'hDEAD;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (ok[0][0] !== 1'b0 || req[0] !== 1'b0) begin n_bad++; $display("FAIL dl_%0d: ok=%b req=%b want 0/0", c, ok[0][0], req[0]); end
        end
        dl = 1'b0; rdy = 2'b00;
        tick();
        n_cmp++; if (req[0] !== 1'b1 || sa[0] !== 22'h20 || ok[0][0] !== 1'b0) begin
            n_bad++; $display("FAIL dl_refetch: req=%b addr=%h ok=%b want 1/20/0", req[0], sa[0], ok[0][0]);
        end
        ack = 2'b11; rdy = 2'b11; rd[0] = 16'h5A5A; rd[1] = 16'h5A5A;
        tick();
        ack = 2'b00; rdy = 2'b00;
        tick();
        n_cmp++; if (ok[0][0] !== 1'b1 || dout[0][15:0] !== 16'h5A5A) begin n_bad++; $display("FAIL dl_hit: ok=%b dout=%h want 1/5a5a", ok[0][0], dout[0][15:0]); end
    endtask

    task automatic test_random();
        int s;
        auto_resp = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 4) == 0) begin
                s = $urandom_range(0, S - 1);
                cs[s] = $urandom_range(0, 3) != 0;
                addr[AW*s +: AW] = AW'($urandom_range(0, 7));
            end
            dl = ($urandom_range(0, 199) == 0) || (dl && $urandom_range(0, 2) != 0);
            tick();
            for (int m = 0; m < 2; m++) begin
                n_cmp++; if (ok[m] !== eok[m]) begin n_bad++; $display("FAIL rnd_ok[%0d] c%0d: got %b want %b", m, c, ok[m], eok[m]); end
                n_cmp++; if (req[m] !== (ph[m] == 1)) begin n_bad++; $display("FAIL rnd_req[%0d] c%0d: got %b want %b", m, c, req[m], ph[m] == 1); end
                n_cmp++; if (sa[m] !== 22'(eaddr[m])) begin n_bad++; $display("FAIL rnd_addr[%0d] c%0d: got %h want %h", m, c, sa[m], eaddr[m]); end
                for (int i = 0; i < S; i++) if (eok[m][i]) begin
                    n_cmp++; if (dout[m][16*i +: 16] !== 16'(edout[m][i])) begin
                        n_bad++; $display("FAIL rnd_dout[%0d][%0d] c%0d: got %h want %h", m, i, c, dout[m][16*i +: 16], edout[m][i]);
                    end
                end
            end
        end
        auto_resp = 1'b0; ack = '0; rdy = '0; dl = 1'b0;
    endtask

    initial begin
        rd[0] = '0; rd[1] = '0;
        test_reset();
        test_miss_fill_hit();
        test_8bit();
        test_arbitration();
        test_addr_change();
        test_download();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
